jump_target_unit: RTL and testbench

Parametrised, registered successor to the combinational jump-address shifter in the multicycle MIPS datapath. Computes the next-PC target for J, JAL, branch, JR and return operations and keeps a small return-address stack (RAS) that is pushed on JAL and popped on return. It sits between the instruction register / register file and the `mux_pcsource` jump input. Requests use a start/valid handshake, and the control unit waits for `valid` before writing PC.

---
 rtl/jump_target_unit.sv | 208 ++++++++++++++++++++
 tb/tb_jump_target_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jump_target_unit.sv
// jump_target_unit
// Registered next-PC target generator for the multicycle MIPS datapath.
// Handles J, JAL, BRANCH, JR and RET requests. JAL pushes its return
// address onto a small circular return-address stack (RAS). RET pops it.
// Each request takes three cycles: IDLE accepts it, CALC evaluates it, and
// DONE presents the result for one cycle.
//
// Ports
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   start, mode     : request pulse (IDLE only) and operation select
//   pc, rs, rt,     : PC+4 and instruction fields
//   offset
//   reg_val         : register operand (JR target / RET fallback)
//   ras_flush       : synchronous RAS clear
//   target, valid   : registered result and its one-cycle strobe
//   busy            : request in flight (CALC or DONE)
//   err_misalign    : JR/RET register target not instruction-aligned
//   err_underflow   : RET with an empty RAS
//   ras_count, ras_full, ras_empty : stack occupancy
module jump_target_unit #(
  parameter int ADDR_W    = 32,
  parameter int SHIFT     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2:0]                   mode,
  input  logic [ADDR_W-1:0]            pc,
  input  logic [4:0]                   rs,
  input  logic [4:0]                   rt,
  input  logic [15:0]                  offset,
  input  logic [ADDR_W-1:0]            reg_val,
  input  logic                         ras_flush,
  output logic [ADDR_W-1:0]            target,
  output logic                         valid,
  output logic                         busy,
  output logic                         err_misalign,
  output logic                         err_underflow,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t              state, next_state;
  logic [2:0]          lat_mode;
  logic [ADDR_W-1:0]   lat_pc, lat_reg;
  logic [4:0]          lat_rs, lat_rt;
  logic [15:0]         lat_off;
  logic [ADDR_W-1:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [ADDR_W-1:0]   jump_tgt, br_off, calc_target;
  logic                calc_mis, calc_uf, do_push, do_pop, push_en, pop_en;
  logic                misal, eff_empty;
  logic [CW-1:0]       next_count;
  logic [PW-1:0]       top_idx;

  assign jump_tgt  = {lat_pc[ADDR_W-1:26+SHIFT], lat_rs, lat_rt, lat_off, {SHIFT{1'b0}}};
  assign br_off    = {{(ADDR_W-16){lat_off[15]}}, lat_off} << SHIFT;
  assign misal     = (lat_reg[SHIFT-1:0] != {SHIFT{1'b0}});
  // A flush on the pop edge wins, so the stack is treated as already empty.
  assign eff_empty = (ras_count == CNT_ZERO) || ras_flush;
  // wr_ptr is the next free slot, so the newest entry sits just below it.
  assign top_idx   = wr_ptr - PTR_ONE;
  assign push_en   = (state == CALC) && do_push;
  assign pop_en    = (state == CALC) && do_pop;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC; else next_state = IDLE;
      CALC:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result evaluation from the latched request.
  always_comb begin
    calc_target = lat_pc;
    calc_mis    = 1'b0;
    calc_uf     = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    case (lat_mode)
      3'b000: calc_target = jump_tgt;
      3'b001: begin
        calc_target = jump_tgt;
        do_push     = 1'b1;
      end
      3'b010: calc_target = lat_pc + br_off;
      3'b011: begin
        calc_target = lat_reg;
        calc_mis    = misal;
      end
      3'b100: begin
        if (eff_empty) begin
          calc_target = lat_reg;
          calc_uf     = 1'b1;
          calc_mis    = misal;
        end else begin
          calc_target = ras_mem[top_idx];
          do_pop      = 1'b1;
        end
      end
      default: calc_target = lat_pc;
    endcase
  end

  // Stack occupancy. A flush clears the stack before a same-edge push lands.
  always_comb begin
    next_count = ras_count;
    if (ras_flush) begin
      if (push_en) next_count = CNT_ONE; else next_count = CNT_ZERO;
    end else if (push_en) begin
      if (ras_count == CNT_DEPTH) next_count = CNT_DEPTH;
      else                        next_count = ras_count + CNT_ONE;
    end else if (pop_en) begin
      next_count = ras_count - CNT_ONE;
    end else begin
      next_count = ras_count;
    end
  end

  // Request capture in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_mode <= 3'b000;
      lat_pc   <= {ADDR_W{1'b0}};
      lat_reg  <= {ADDR_W{1'b0}};
      lat_rs   <= 5'd0;
      lat_rt   <= 5'd0;
      lat_off  <= 16'd0;
    end else if (state == IDLE && start) begin
      lat_mode <= mode;
      lat_pc   <= pc;
      lat_reg  <= reg_val;
      lat_rs   <= rs;
      lat_rt   <= rt;
      lat_off  <= offset;
    end
  end

  // RAS write pointer. It wraps, so an overflowing push overwrites the oldest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= {PW{1'b0}};
    end else if (push_en) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end else if (pop_en) begin
      wr_ptr <= wr_ptr - PTR_ONE;
    end
  end

  // RAS storage. No reset is needed because ras_count qualifies every read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_mem[wr_ptr] <= lat_pc;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target        <= {ADDR_W{1'b0}};
      valid         <= 1'b0;
      busy          <= 1'b0;
      err_misalign  <= 1'b0;
      err_underflow <= 1'b0;
      ras_count     <= CNT_ZERO;
      ras_full      <= 1'b0;
      ras_empty     <= 1'b1;
    end else begin
      valid     <= (state == CALC);
      busy      <= (next_state != IDLE);
      ras_count <= next_count;
      ras_full  <= (next_count == CNT_DEPTH);
      ras_empty <= (next_count == CNT_ZERO);
      if (state == CALC) begin
        target        <= calc_target;
        err_misalign  <= calc_mis;
        err_underflow <= calc_uf;
      end else if (state == IDLE && start) begin
        err_misalign  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jump_target_unit.sv
// Directed self-checking bench for jump_target_unit (default parameters).
module tb_jump_target_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mode;
  logic [31:0] pc, reg_val, target;
  logic [4:0]  rs, rt;
  logic [15:0] offset;
  logic        ras_flush, valid, busy, err_misalign, err_underflow;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] M_J = 3'b000, M_JAL = 3'b001, M_BR = 3'b010,
                         M_JR = 3'b011, M_RET = 3'b100, M_RSV = 3'b111;

  jump_target_unit dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .pc(pc),
    .rs(rs), .rt(rt), .offset(offset), .reg_val(reg_val),
    .ras_flush(ras_flush), .target(target), .valid(valid), .busy(busy),
    .err_misalign(err_misalign), .err_underflow(err_underflow),
    .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and returns at the negedge of the DONE cycle.
  task automatic do_op(input logic [2:0] m, input logic [31:0] p, input logic [4:0] s,
                       input logic [4:0] t, input logic [15:0] o, input logic [31:0] r,
                       input logic fl);
    int guard;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
    mode = m; pc = p; rs = s; rt = t; offset = o; reg_val = r;
    ras_flush = fl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_calc", {31'd0, busy}, 32'd1);
    check("valid_early", {31'd0, valid}, 32'd0);
    @(negedge clk);
    ras_flush = 1'b0;
    check("valid_pulse", {31'd0, valid}, 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic [31:0] tgt, input logic mis,
                         input logic uf, input logic [2:0] cnt);
    check({tag, "_target"}, target, tgt);
    check({tag, "_mis"}, {31'd0, err_misalign}, {31'd0, mis});
    check({tag, "_uf"}, {31'd0, err_underflow}, {31'd0, uf});
    check({tag, "_count"}, {29'd0, ras_count}, {29'd0, cnt});
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_target"}, target, 32'd0);
    check({tag, "_flags"},
          {25'd0, valid, busy, err_misalign, err_underflow, ras_count == 3'd0, ras_full, ras_empty},
          {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
  endtask

  initial begin
    logic [31:0] ov_ret [4];
    reset = 1'b0; start = 1'b0; mode = 3'b000; pc = 32'd0; rs = 5'd0; rt = 5'd0;
    offset = 16'd0; reg_val = 32'd0; ras_flush = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;

    // J: upper PC nibble kept, all-ones fields shifted left by 2.
    do_op(M_J, 32'hA000_0004, 5'h1F, 5'h1F, 16'hFFFF, 32'd0, 1'b0);
    chk_res("j", 32'hAFFF_FFFC, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    check("valid_one_cycle", {31'd0, valid}, 32'd0);

    // BRANCH wrap-around and negative offset.
    do_op(M_BR, 32'hFFFF_FFFC, 5'd0, 5'd0, 16'h0002, 32'd0, 1'b0);
    chk_res("br_wrap", 32'h0000_0004, 1'b0, 1'b0, 3'd0);
    do_op(M_BR, 32'h0000_1000, 5'd0, 5'd0, 16'hFFFF, 32'd0, 1'b0);
    chk_res("br_neg", 32'h0000_0FFC, 1'b0, 1'b0, 3'd0);

    // JAL/RET LIFO. JAL target with offset 0x40 and upper nibble 0 is 0x100.
    do_op(M_JAL, 32'h100, 5'd0, 5'd0, 16'h0040, 32'd0, 1'b0);
    chk_res("jal1", 32'h100, 1'b0, 1'b0, 3'd1);
    do_op(M_JAL, 32'h200, 5'd0, 5'd0, 16'h0000, 32'd0, 1'b0);
    check("jal2_count", {29'd0, ras_count}, 32'd2);
    do_op(M_JAL, 32'h300, 5'd0, 5'd0, 16'h0000, 32'd0, 1'b0);
    check("jal3_count", {29'd0, ras_count}, 32'd3);
    do_op(M_RET, 32'd0, 5'd0, 5'd0, 16'd0, 32'h0, 1'b0);
    chk_res("ret1", 32'h300, 1'b0, 1'b0, 3'd2);
    do_op(M_RET, 32'd0, 5'd0, 5'd0, 16'd0, 32'h0, 1'b0);
    chk_res("ret2", 32'h200, 1'b0, 1'b0, 3'd1);
    do_op(M_RET, 32'd0, 5'd0, 5'd0, 16'd0, 32'h0, 1'b0);
    chk_res("ret3", 32'h100, 1'b0, 1'b0, 3'd0);
    check("lifo_empty", {31'd0, ras_empty}, 32'd1);

    // RAS overflow: five pushes into four entries drop 0x10.
    for (int i = 1; i <= 5; i++) begin
      do_op(M_JAL, 32'h10 * i, 5'd0, 5'd0, 16'd0, 32'd0, 1'b0);
      check("ovf_full", {31'd0, ras_full}, (i >= 4) ? 32'd1 : 32'd0);
    end
    check("ovf_count", {29'd0, ras_count}, 32'd4);
    ov_ret[0] = 32'h50; ov_ret[1] = 32'h40; ov_ret[2] = 32'h30; ov_ret[3] = 32'h20;
    for (int i = 0; i < 4; i++) begin
      do_op(M_RET, 32'd0, 5'd0, 5'd0, 16'd0, 32'h0, 1'b0);
      chk_res("ovf_ret", ov_ret[i], 1'b0, 1'b0, 3'(3 - i));
    end
    do_op(M_RET, 32'd0, 5'd0, 5'd0, 16'd0, 32'h0000_0A00, 1'b0);
    chk_res("ovf_under", 32'h0000_0A00, 1'b0, 1'b1, 3'd0);

    // JR misaligned target.
    do_op(M_JR, 32'd0, 5'd0, 5'd0, 16'd0, 32'h0000_0102, 1'b0);
    chk_res("jr_mis", 32'h0000_0102, 1'b1, 1'b0, 3'd0);

    // Start held high through CALC and DONE. Only one result may appear.
    @(negedge clk);
    mode = M_JR; reg_val = 32'h0000_0200; start = 1'b1;
    @(negedge clk);
    check("mis_cleared", {31'd0, err_misalign}, 32'd0);
    @(negedge clk);
    check("busy_valid", {31'd0, valid}, 32'd1);
    mode = M_J; reg_val = 32'h0000_0333;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("busy_ignored", {31'd0, valid}, 32'd0);
      @(negedge clk);
    end
    chk_res("busy_res", 32'h0000_0200, 1'b0, 1'b0, 3'd0);

    // RET on an empty stack with a misaligned fallback, and a reserved mode.
    do_op(M_RET, 32'd0, 5'd0, 5'd0, 16'd0, 32'h0000_0103, 1'b0);
    chk_res("ret_empty", 32'h0000_0103, 1'b1, 1'b1, 3'd0);
    do_op(M_RSV, 32'h0000_1234, 5'h3, 5'h4, 16'h5, 32'h0000_0107, 1'b0);
    chk_res("reserved", 32'h0000_1234, 1'b0, 1'b0, 3'd0);

    // Flush coincident with a push leaves one entry holding the pushed PC.
    do_op(M_JAL, 32'h40, 5'd0, 5'd0, 16'd0, 32'd0, 1'b0);
    do_op(M_JAL, 32'h44, 5'd0, 5'd0, 16'd0, 32'd0, 1'b0);
    check("pre_flush_count", {29'd0, ras_count}, 32'd2);
    do_op(M_JAL, 32'h80, 5'd0, 5'd0, 16'd0, 32'd0, 1'b1);
    check("flush_push_count", {29'd0, ras_count}, 32'd1);
    do_op(M_RET, 32'd0, 5'd0, 5'd0, 16'd0, 32'h0, 1'b0);
    chk_res("flush_push_ret", 32'h80, 1'b0, 1'b0, 3'd0);

    // Flush coincident with a pop falls back to reg_val as an underflow.
    do_op(M_JAL, 32'h90, 5'd0, 5'd0, 16'd0, 32'd0, 1'b0);
    do_op(M_RET, 32'd0, 5'd0, 5'd0, 16'd0, 32'h0000_0500, 1'b1);
    chk_res("flush_pop", 32'h0000_0500, 1'b0, 1'b1, 3'd0);

    // Asynchronous reset during CALC.
    do_op(M_JAL, 32'hC0, 5'd0, 5'd0, 16'd0, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    mode = M_JAL; pc = 32'h700; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_valid_after_reset", {30'd0, valid, busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
